// File: rtl/sel_sequencer.sv
// sel_sequencer: round-robin select sequencer for a 4:1 downstream mux.
// Offers one requesting channel at a time, waits for acceptance, then holds
// the select for DWELL cycles before re-arbitrating from the next channel.
module sel_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ack,
    output logic       s1,
    output logic       s2,
    output logic [3:0] onehot,
    output logic       valid,
    output logic [7:0] grant_cnt
);

    typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;     // granted channel index, also drives {s2,s1}
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] onehot_d;
    logic       valid_d;
    logic [7:0] gcnt_d;

    logic [3:0] req_idx;          // req re-ordered so bit i is channel index i
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;

    assign s1 = sel_q[0];
    assign s2 = sel_q[1];

    // Round-robin search starting at ptr: first requesting channel wins.
    always_comb begin
        req_idx = {req[0], req[1], req[2], req[3]};
        found   = 1'b0;
        pick    = ptr_q;
        cand    = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req_idx[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        onehot_d = onehot;
        valid_d  = valid;
        gcnt_d   = grant_cnt;
        case (state_q)
            IDLE: begin
                valid_d  = 1'b0;
                onehot_d = 4'b0000;
                if (found) begin
                    state_d  = OFFER;
                    sel_d    = pick;
                    onehot_d = 4'b1000 >> pick;
                    valid_d  = 1'b1;
                end
            end
            OFFER: begin
                // Acceptance wins over a request dropped in the same cycle.
                if (ack) begin
                    state_d = HOLD;
                    cnt_d   = DWELL_LOAD;
                    gcnt_d  = grant_cnt + 8'd1;
                    valid_d = 1'b0;
                end else if (!req_idx[sel_q]) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    onehot_d = 4'b0000;
                end
            end
            HOLD: begin
                valid_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d  = IDLE;
                    onehot_d = 4'b0000;
                    ptr_d    = sel_q + 2'd1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                onehot_d = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            cnt_q     <= 4'd0;
            onehot    <= 4'b0000;
            valid     <= 1'b0;
            grant_cnt <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            onehot    <= onehot_d;
            valid     <= valid_d;
            grant_cnt <= gcnt_d;
        end
    end

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed bench for sel_sequencer: DWELL=4 instance for most scenarios,
// DWELL=1 instance for the single-cycle hold and grant counter wrap.
module tb_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, req1;
    logic       ack, ack1;
    logic       s1, s2, valid, s1b, s2b, valid1;
    logic [3:0] onehot, onehot1;
    logic [7:0] grant_cnt, grant_cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sel_sequencer #(.DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .s1(s1), .s2(s2), .onehot(onehot), .valid(valid), .grant_cnt(grant_cnt)
    );

    sel_sequencer #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .ack(ack1),
        .s1(s1b), .s2(s2b), .onehot(onehot1), .valid(valid1), .grant_cnt(grant_cnt1)
    );

    // Advance one rising edge; outputs are then sampled at the falling edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0; ack = 1'b0; req1 = 4'b0; ack1 = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", valid); end
        tests++; if (onehot !== 4'b0000) begin fails++; $display("FAIL reset_onehot: got %b exp 0000", onehot); end
        tests++; if ({s2, s1} !== 2'b00) begin fails++; $display("FAIL reset_sel: got %b exp 00", {s2, s1}); end
        tests++; if (grant_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", grant_cnt); end
        // ack while idle must not change anything
        ack = 1'b1;
        step();
        ack = 1'b0;
        tests++; if (valid !== 1'b0 || onehot !== 4'b0000 || grant_cnt !== 8'd0) begin
            fails++; $display("FAIL idle_ack: got valid=%b onehot=%b cnt=%0d exp 0 0000 0", valid, onehot, grant_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0010;
        step();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b exp 1", valid); end
        tests++; if (onehot !== 4'b0010) begin fails++; $display("FAIL single_onehot: got %b exp 0010", onehot); end
        tests++; if ({s2, s1} !== 2'b10) begin fails++; $display("FAIL single_sel: got %b exp 10", {s2, s1}); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 4'b1111;   // request changes during HOLD have no effect
        tests++; if (valid !== 1'b0 || grant_cnt !== 8'd1) begin
            fails++; $display("FAIL single_accept: got valid=%b cnt=%0d exp 0 1", valid, grant_cnt);
        end
        step(3);
        tests++; if (onehot !== 4'b0010 || {s2, s1} !== 2'b10 || valid !== 1'b0) begin
            fails++; $display("FAIL single_hold: got onehot=%b sel=%b valid=%b exp 0010 10 0", onehot, {s2, s1}, valid);
        end
        step();
        tests++; if (onehot !== 4'b0000 || valid !== 1'b0) begin
            fails++; $display("FAIL single_idle: got onehot=%b valid=%b exp 0000 0", onehot, valid);
        end
        tests++; if ({s2, s1} !== 2'b10) begin fails++; $display("FAIL single_sel_hold: got %b exp 10", {s2, s1}); end
        step();
        tests++; if (onehot !== 4'b0001 || {s2, s1} !== 2'b11 || valid !== 1'b1) begin
            fails++; $display("FAIL single_ptr3: got onehot=%b sel=%b valid=%b exp 0001 11 1", onehot, {s2, s1}, valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        logic [1:0] exp_sel;
        do_reset();
        req = 4'b1111;
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();   // IDLE -> OFFER
            exp_sel = 2'(i % 4);
            exp_oh  = 4'b1000 >> (i % 4);
            tests++; if (valid !== 1'b1 || onehot !== exp_oh || {s2, s1} !== exp_sel) begin
                fails++; $display("FAIL rr_grant%0d: got valid=%b onehot=%b sel=%b exp 1 %b %b", i, valid, onehot, {s2, s1}, exp_oh, exp_sel);
            end
            step();   // accept
            if (i < 4) step(4);   // remaining HOLD cycles and IDLE
        end
        tests++; if (grant_cnt !== 8'd5) begin fails++; $display("FAIL rr_count: got %0d exp 5", grant_cnt); end
        ack = 1'b0;
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b1000;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 4'b0000;
        step(4);   // back to IDLE with ptr = 1
        tests++; if (grant_cnt !== 8'd1 || onehot !== 4'b0000) begin
            fails++; $display("FAIL wd_setup: got cnt=%0d onehot=%b exp 1 0000", grant_cnt, onehot);
        end
        req = 4'b0100;
        step();
        tests++; if (valid !== 1'b1 || onehot !== 4'b0100) begin
            fails++; $display("FAIL wd_offer: got valid=%b onehot=%b exp 1 0100", valid, onehot);
        end
        req = 4'b0000;
        step();
        tests++; if (valid !== 1'b0 || onehot !== 4'b0000 || grant_cnt !== 8'd1) begin
            fails++; $display("FAIL wd_idle: got valid=%b onehot=%b cnt=%0d exp 0 0000 1", valid, onehot, grant_cnt);
        end
        req = 4'b1100;   // ptr still 1 -> b ahead of a
        step();
        tests++; if (valid !== 1'b1 || onehot !== 4'b0100 || {s2, s1} !== 2'b01) begin
            fails++; $display("FAIL wd_rearb: got valid=%b onehot=%b sel=%b exp 1 0100 01", valid, onehot, {s2, s1});
        end
    endtask

    // Continues from the b offer left by test_withdraw.
    task automatic test_ack_drop();
        ack = 1'b1;
        req = 4'b0000;
        step();
        ack = 1'b0;
        tests++; if (valid !== 1'b0 || onehot !== 4'b0100 || grant_cnt !== 8'd2) begin
            fails++; $display("FAIL ackdrop: got valid=%b onehot=%b cnt=%0d exp 0 0100 2", valid, onehot, grant_cnt);
        end
    endtask

    // Continues from the HOLD left by test_ack_drop.
    task automatic test_reset_mid_hold();
        rst_n = 1'b0;
        step();
        tests++; if (valid !== 1'b0 || onehot !== 4'b0000 || {s2, s1} !== 2'b00 || grant_cnt !== 8'd0) begin
            fails++; $display("FAIL rst_hold: got valid=%b onehot=%b sel=%b cnt=%0d exp 0 0000 00 0", valid, onehot, {s2, s1}, grant_cnt);
        end
        rst_n = 1'b1;
        req = 4'b0001;
        step();
        tests++; if (valid !== 1'b1 || onehot !== 4'b0001 || {s2, s1} !== 2'b11) begin
            fails++; $display("FAIL rst_regrant: got valid=%b onehot=%b sel=%b exp 1 0001 11", valid, onehot, {s2, s1});
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap_dwell1();
        logic [3:0] exp_oh;
        do_reset();
        req1 = 4'b1111;
        ack1 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();   // OFFER
            step();   // accepted, single HOLD cycle
            if (i < 2 || i >= 254) begin
                exp_oh = 4'b1000 >> (i % 4);
                tests++; if (valid1 !== 1'b0 || onehot1 !== exp_oh || grant_cnt1 !== 8'(i + 1)) begin
                    fails++; $display("FAIL d1_hold%0d: got valid=%b onehot=%b cnt=%0d exp 0 %b %0d", i, valid1, onehot1, grant_cnt1, exp_oh, 8'(i + 1));
                end
            end
            step();   // back to IDLE after exactly one HOLD cycle
            if (i < 2 || i == 255) begin
                tests++; if (onehot1 !== 4'b0000 || valid1 !== 1'b0) begin
                    fails++; $display("FAIL d1_idle%0d: got onehot=%b valid=%b exp 0000 0", i, onehot1, valid1);
                end
            end
        end
        tests++; if (grant_cnt1 !== 8'd0) begin fails++; $display("FAIL d1_wrap: got %0d exp 0", grant_cnt1); end
        ack1 = 1'b0;
        req1 = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0; ack = 1'b0; req1 = 4'b0; ack1 = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_ack_drop();
        test_reset_mid_hold();
        test_wrap_dwell1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sel_sequencer.md
SEL_SEQUENCER -- requirements
Module: sel_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning the number of cycles (legal range 1..15) a granted select is held after acceptance.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req  input  4  channel requests; bit3=channel a, bit2=b, bit1=c, bit0=d.
REQ-005 SHALL have port ack  input  1  downstream mux acceptance of the presented select.
REQ-006 SHALL have port s1  output  1  select bit 1 (LSB of the channel index).
REQ-007 SHALL have port s2  output  1  select bit 2 (MSB of the channel index).
REQ-008 SHALL have port onehot  output  4  granted channel one-hot: a=1000, b=0100, c=0010, d=0001; 0000 when nothing is granted.
REQ-009 SHALL have port valid  output  1  high while a grant is offered and awaiting ack.
REQ-010 SHALL have port grant_cnt  output  8  count of accepted grants.

Function
REQ-011 SHALL encode channel to {s2,s1} as a=00, b=01, c=10, d=11.
REQ-012 SHALL implement three states: IDLE, OFFER, HOLD.
REQ-013 SHALL keep a 2-bit round-robin pointer, ptr, naming the highest-priority channel; search order is ptr, ptr+1, ... with index 0=a through 3=d, modulo 4.
REQ-014 IDLE: if req!=0, SHALL select the first requesting channel in round-robin order and enter OFFER on the next edge; valid, onehot, s1 and s2 update on that same edge (1-cycle latency).
REQ-015 IDLE: if req==0, SHALL stay in IDLE with valid=0 and onehot=0000; s1/s2 SHALL hold their last values.
REQ-016 OFFER: valid=1, and onehot, s1 and s2 SHALL remain stable until leaving OFFER.
REQ-017 OFFER with ack=1: SHALL enter HOLD, load the dwell counter with DWELL-1, increment grant_cnt, and deassert valid on the next edge.
REQ-018 OFFER with ack=0 and the granted channel's req=0: SHALL withdraw to IDLE with valid=0, onehot=0000, ptr unchanged, and grant_cnt unchanged.
REQ-019 OFFER with ack=1 and the granted req dropped in the same cycle: ack SHALL take priority (REQ-017 applies).
REQ-020 HOLD: valid=0; onehot, s1 and s2 SHALL stay at the granted channel; the counter SHALL decrement each cycle.
REQ-021 HOLD with counter==0: SHALL enter IDLE on the next edge, set onehot=0000, and set ptr to granted index+1 mod 4 (d wraps to a).
REQ-022 With DWELL=1, HOLD SHALL last exactly one cycle.
REQ-023 ack in IDLE or HOLD SHALL be ignored.
REQ-024 grant_cnt SHALL wrap from 255 to 0 without saturation.
REQ-025 Changes to req during HOLD SHALL have no effect until return to IDLE.
REQ-026 Outputs SHALL be registered; no combinational path from req or ack to any output.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL enter IDLE with ptr=0 (a), s1=0, s2=0, onehot=0000, valid=0, grant_cnt=0, and dwell counter=0.
REQ-028 Reset SHALL override any state, including mid-OFFER or mid-HOLD, and SHALL take effect at the first edge with rst_n=0.
REQ-029 The first edge with rst_n=1 SHALL be able to sample req as a normal IDLE cycle.

Verification
REQ-030 Single request: after reset, req=0010 -> next edge gives valid=1, onehot=0010, {s2,s1}=10; ack=1 one cycle -> valid=0; HOLD lasts 4 cycles; then IDLE, ptr=3.
REQ-031 Round-robin fairness: req=1111 held, ack tied 1 -> grants in order a,b,c,d,a; grant_cnt=5 after five grants; {s2,s1} sequence 00,01,10,11,00.
REQ-032 Withdrawal: offer to b (req=0100), drop req to 0000 before ack -> IDLE next edge, onehot=0000, grant_cnt unchanged, next request re-arbitrates from ptr=1.
REQ-033 Simultaneous ack and req drop during OFFER -> grant accepted, grant_cnt increments, HOLD entered.
REQ-034 Reset mid-HOLD: rst_n=0 for one edge during HOLD -> all outputs at reset values on that edge; req=0001 afterwards -> d granted with {s2,s1}=11.
REQ-035 Counter wrap and DWELL=1: with DWELL=1, accept 256 grants -> grant_cnt=0, and each HOLD lasts exactly one cycle.
